// File: rtl/isa_pkg.sv
// ISA definitions shared by the instruction encoder/loader and its packer:
// opcode width, instruction formats, field bit positions and loader FSM states.
package isa_pkg;

    localparam int OPCODE_W = 5;
    localparam int REG_W    = 5;
    localparam int WORD_W   = 32;
    localparam int IMM_I_W  = 17;
    localparam int IMM_J_W  = 27;

    // Field bit positions (LSB) inside the 32-bit machine word
    localparam int OP_LSB = 27;
    localparam int RS_LSB = 22;
    localparam int RT_LSB = 17;
    localparam int RD_LSB = 12;

    typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} instr_fmt_t;

    typedef enum logic [1:0] {IDLE, WRITE, ERR} state_t;

    // Opcode-to-format map, identical to the one the main decoder uses
    function automatic instr_fmt_t fmtOf(input logic [OPCODE_W-1:0] op);
        if (op == '0) begin
            return FMT_R;
        end else if (op[OPCODE_W-1:OPCODE_W-2] == 2'b11) begin
            return FMT_J;
        end else begin
            return FMT_I;
        end
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Field-bundle stream into the instruction encoder/loader (valid/ready).
interface instr_encoder_loader_if;
    import isa_pkg::*;

    logic                inValid;
    logic                inReady;
    logic [OPCODE_W-1:0] opCode;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [WORD_W-1:0]   imm;

    modport master (output inValid, opCode, rs, rt, rd, imm, input inReady);
    modport slave  (input inValid, opCode, rs, rt, rd, imm, output inReady);

endinterface

// File: rtl/instr_packer.sv
// Combinational packer: instruction fields -> 32-bit machine word plus an
// immediate range error. Shared with the assembler bench.
module instr_packer
    import isa_pkg::*;
(
    input  logic [OPCODE_W-1:0] op_code,
    input  logic [REG_W-1:0]    rs,
    input  logic [REG_W-1:0]    rt,
    input  logic [REG_W-1:0]    rd,
    input  logic [WORD_W-1:0]   imm,
    output logic [WORD_W-1:0]   word,
    output logic                range_err
);

    // Select the format and pack; I-type imm must be a 17-bit signed value,
    // J-type target must fit in 27 unsigned bits.
    always_comb begin
        word      = '0;
        range_err = 1'b0;
        case (fmtOf(op_code))
            FMT_R: begin
                word = {op_code, rs, rt, rd, 12'b0};
            end
            FMT_J: begin
                word      = {op_code, imm[IMM_J_W-1:0]};
                range_err = |imm[WORD_W-1:IMM_J_W];
            end
            default: begin
                word      = {op_code, rs, rt, imm[IMM_I_W-1:0]};
                range_err = !((&imm[WORD_W-1:IMM_I_W-1]) || !(|imm[WORD_W-1:IMM_I_W-1]));
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts field bundles, packs them into machine
// words and writes them sequentially into instruction memory (one word per
// two cycles). Optional feature macro: INSTR_CHECKSUM_EN adds a running XOR
// checksum of every written word on port checksum.
module instr_encoder_loader
    import isa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  clear,
    instr_encoder_loader_if.slave in_bus,
    output logic                  memWe,
    output logic [ADDR_W-1:0]     memAddr,
    output logic [WORD_W-1:0]     memWData,
    output logic [ADDR_W:0]       wordCount,
    output logic                  full,
    output logic                  encErr
`ifdef INSTR_CHECKSUM_EN
    ,
    output logic [WORD_W-1:0]     checksum
`endif
);

    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                started_q, started_d;
`ifdef INSTR_CHECKSUM_EN
    logic [WORD_W-1:0]   checksum_q, checksum_d;
`endif

    logic [WORD_W-1:0]   packed_word;
    logic                range_err;
    logic                ready;
    logic                xfer;

    instr_packer u_packer (
        .op_code   (in_bus.opCode),
        .rs        (in_bus.rs),
        .rt        (in_bus.rt),
        .rd        (in_bus.rd),
        .imm       (in_bus.imm),
        .word      (packed_word),
        .range_err (range_err)
    );

    assign full           = (count_q == DEPTH_C);
    assign ready          = started_q && (state_q == IDLE) && !full && !clear;
    assign xfer           = in_bus.inValid && ready;
    assign in_bus.inReady = ready;
    assign memWe          = (state_q == WRITE);
    assign encErr         = (state_q == ERR);
    assign memAddr        = addr_q;
    assign memWData       = wdata_q;
    assign wordCount      = count_q;
`ifdef INSTR_CHECKSUM_EN
    assign checksum       = checksum_q;
`endif

    // Next state: accept a bundle in IDLE, write or flag it, then advance;
    // clear overrides any pending address/count increment.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        wdata_d   = wdata_q;
        started_d = 1'b1;
`ifdef INSTR_CHECKSUM_EN
        checksum_d = checksum_q;
`endif
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (range_err) begin
                        state_d = ERR;
                    end else begin
                        state_d = WRITE;
                        wdata_d = packed_word;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
                addr_d  = addr_q + ADDR_W'(1);
                count_d = count_q + (ADDR_W+1)'(1);
`ifdef INSTR_CHECKSUM_EN
                checksum_d = checksum_q ^ wdata_q;
`endif
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (clear) begin
            addr_d  = BASE_C;
            count_d = '0;
`ifdef INSTR_CHECKSUM_EN
            checksum_d = '0;
`endif
        end
    end

    // State and datapath registers; reset aborts any in-flight write at once.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            addr_q     <= BASE_C;
            count_q    <= '0;
            wdata_q    <= '0;
            started_q  <= 1'b0;
`ifdef INSTR_CHECKSUM_EN
            checksum_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            wdata_q    <= wdata_d;
            started_q  <= started_d;
`ifdef INSTR_CHECKSUM_EN
            checksum_q <= checksum_d;
`endif
        end
    end

endmodule
